// File: rtl/cal_fifo_reader.sv
// cal_fifo_reader: read-side controller for the calibration FIFO.
// Issues FIFO reads while enabled, tracks words in flight through the FIFO's
// read latency, parks returning words in a small circular skid buffer and
// presents them as a valid/ready stream with a per-frame last marker.
module cal_fifo_reader #(
  parameter int DWIDTH     = 12,
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4,
  parameter int FRAME_LEN  = 512
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              FIFO_EMPTY,
  input  logic [DWIDTH-1:0] FIFO_Q,
  output logic              FIFO_RE,
  output logic [DWIDTH-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST,
  output logic              BUSY,
  output logic [15:0]       FRAME_CNT
);

  localparam int CNT_W = $clog2(SKID_DEPTH + RD_LATENCY + 1);
  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam logic [CNT_W-1:0] SKID_D   = CNT_W'(SKID_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);
  localparam logic [15:0]      IDX_LAST = 16'(FRAME_LEN - 1);

  // Credits must cover the full read latency plus one word of slack so the
  // conservative credit check still sustains one word per cycle.
  if (SKID_DEPTH < RD_LATENCY + 2) begin : g_skid_too_small
    $error("cal_fifo_reader: SKID_DEPTH must be >= RD_LATENCY+2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [CNT_W-1:0]      inflight;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [15:0]           idx_q, idx_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [DWIDTH-1:0]     skid_mem [SKID_DEPTH];
  logic                  push, pop;

  // Circular pointer advance for a buffer that need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Words in flight, read-enable credit check and stream-side outputs.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(rd_vld_q[i]);
    end
    FIFO_RE   = !RESET && (state_q == RUN) && ENABLE && !FIFO_EMPTY &&
                ((inflight + occ_q) < SKID_D);
    push      = rd_vld_q[RD_LATENCY-1];
    M_VALID   = (occ_q != '0);
    pop       = M_VALID && M_READY;
    M_DATA    = M_VALID ? skid_mem[rd_ptr_q] : '0;
    M_LAST    = M_VALID && (idx_q == IDX_LAST);
    BUSY      = (state_q != IDLE);
    FRAME_CNT = frame_cnt_q;
  end

  // Next-state for the FSM, latency pipe, skid pointers and frame counters.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ENABLE) state_d = RUN;
      RUN:     if (!ENABLE) state_d = DRAIN;
      DRAIN: begin
        if (ENABLE)                                state_d = RUN;
        else if (inflight == '0 && occ_q == '0)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_vld_d[0] = FIFO_RE;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
    end

    occ_d    = occ_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;

    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    if (pop) begin
      if (idx_q == IDX_LAST) begin
        idx_d       = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        idx_d = idx_q + 16'd1;
      end
    end
  end

  // Control registers; reset discards in-flight and buffered words.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      rd_vld_q    <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_vld_q    <= rd_vld_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Skid storage: capture FIFO_Q when the oldest in-flight read lands.
  always_ff @(posedge CLK) begin
    if (push) begin
      skid_mem[wr_ptr_q] <= FIFO_Q;
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (RESET) occ_q <= SKID_D);

endmodule
